axi4lite_mem_slave: RTL
=======================

Name: axi4lite_mem_slave

Overview:
- AXI4-Lite responder: a single-port word memory on the far end of the mriscvcore AXI4-Lite master port. Used as instruction/data RAM in core-level benches and FPGA builds.
- Signal names mirror the core's bus: AWdata and ARdata carry addresses; there are no BRESP/RRESP channels.
- Write channel (AW/W/B) and read channel (AR/R) run independent state machines over one shared memory array.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, extra response delay in cycles; used only when AXI_SLAVE_WAIT_EN is defined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- AWdata  in  32  write byte address.
- AWvalid  in  1  write address valid.
- AWready  out  1  write address accepted.
- AWprot  in  3  ignored.
- Wdata  in  32  write data.
- Wstrb  in  4  byte enables; bit i covers Wdata[8i+7:8i].
- Wvalid  in  1  write data valid.
- Wready  out  1  write data accepted.
- Bvalid  out  1  write response valid.
- Bready  in  1  write response taken.
- ARdata  in  32  read byte address.
- ARvalid  in  1  read address valid.
- ARready  out  1  read address accepted.
- ARprot  in  3  ignored.
- Rdata  out  32  read data.
- Rvalid  out  1  read data valid.
- RReady  in  1  read data taken.

Behaviour:
- Reset (asynchronous, active-high):
  - AWready=1, Wready=1, ARready=1, Bvalid=0, Rvalid=0, Rdata=0.
  - Both FSMs go to IDLE. Memory contents are not cleared.
  - Reset mid-transaction aborts it; any write not yet committed is lost.
- Address decode:
  - offset = addr - BASE_ADDR; word index = offset[ADDR_WIDTH+1:2]; offset[1:0] ignored.
  - In range means offset < 4*2^ADDR_WIDTH (unsigned).
- Write FSM, states W_IDLE, W_RESP (plus W_WAIT with the optional feature):
  - W_IDLE: AW and W are captured independently.
    - AWvalid&AWready captures the address and drops AWready.
    - Wvalid&Wready captures data and strobes and drops Wready.
    - Both may be captured in the same cycle, in either order, any number of cycles apart.
  - Commit happens on the edge where the second of AW/W is captured (or both together): bytes with Wstrb=1 are written.
    - Wstrb=0 is a legal no-op.
    - An out-of-range address drops the write silently but still produces a response.
  - Next cycle: Bvalid=1, state W_RESP.
  - W_RESP: Bvalid holds until Bready=1. On that edge Bvalid=0, AWready=Wready=1, back to W_IDLE.
  - Minimum write occupancy: handshake cycle, then response cycle.
- Read FSM, states R_IDLE, R_DATA (plus R_WAIT with the optional feature):
  - R_IDLE: ARready=1. On ARvalid&ARready, Rdata is loaded with the addressed word (32'h0 if out of range), ARready=0, Rvalid=1 next cycle, state R_DATA.
  - R_DATA: Rdata and Rvalid are held stable until RReady=1. On that edge Rvalid=0, ARready=1, back to R_IDLE.
  - RReady high before Rvalid has no effect.
- Simultaneous events:
  - A write commit and an AR handshake on the same edge to the same word: the read returns the pre-write value. Any write committed on an earlier edge is visible.
  - The read and write channels never stall each other.
- Valid/ready rules:
  - The slave never drops Bvalid or Rvalid before the handshake.
  - Ready outputs do not depend combinationally on valid inputs; all outputs are registered.

Optional Feature:
- AXI_SLAVE_WAIT_EN defined:
  - After AR capture the read FSM enters R_WAIT for WAIT_CYCLES cycles before Rvalid rises. Rdata is loaded at Rvalid rise, from memory contents at that time.
  - After write commit the write FSM enters W_WAIT for WAIT_CYCLES cycles before Bvalid rises. Ready outputs stay low throughout.
  - WAIT_CYCLES=0 behaves as if the macro were undefined.
- Undefined: no wait states; timing exactly as in Behaviour.

Test Plan:
- Full-word write: AWdata=0x10, Wdata=0xCAFEBABE, Wstrb=4'hF, same cycle -> Bvalid=1 on the following cycle. Then read ARdata=0x10 -> Rvalid=1 one cycle after AR handshake, Rdata=0xCAFEBABE.
- Byte lanes: word at 0x20 preloaded 0x11223344; write Wdata=0xAABBCCDD, Wstrb=4'b0101 -> readback 0x11BB33DD.
- Skewed write:
  - W presented 3 cycles before AW at 0x30: Wready drops after the W capture, no Bvalid until AW arrives.
  - Bready held low 4 cycles: Bvalid stays high, AWready=Wready=0 throughout.
- Read backpressure: RReady low 5 cycles after Rvalid -> Rdata stable and ARready=0 for all 5. Second ARvalid is accepted only after the R handshake.
- Boundaries:
  - Write then read at address 4*2^ADDR_WIDTH-4 round-trips.
  - Read at 4*2^ADDR_WIDTH returns 0x0.
  - Write at 4*2^ADDR_WIDTH gets Bvalid and leaves word 0 unchanged.
- Collision/reset:
  - Word 0x40 holds 0x1. Commit 0x2 on the same edge as an AR handshake to 0x40 -> Rdata=0x1; next read -> 0x2.
  - Assert rst while Bvalid=1 -> Bvalid=0 and all readies=1 immediately.

Source files
------------

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite word-memory responder with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional response wait states are enabled with the AXI_SLAVE_WAIT_EN macro.
module axi4lite_mem_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AWdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [2:0]  AWprot,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic [31:0] ARdata,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [2:0]  ARprot,
    output logic [31:0] Rdata,
    output logic        Rvalid,
    input  logic        RReady
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_WIDTH;

`ifdef AXI_SLAVE_WAIT_EN
    localparam bit          WAIT_ON   = (WAIT_CYCLES != 0);
`else
    localparam bit          WAIT_ON   = 1'b0;
    localparam int          unused_wait_cycles = WAIT_CYCLES;
`endif
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);

    localparam logic [1:0] W_IDLE = 2'd0, W_RESP = 2'd1, W_WAIT = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd1, R_WAIT = 2'd2;

    logic [31:0] mem [DEPTH];

    logic        unused_prot;
    assign unused_prot = ^{AWprot, ARprot};

    logic [1:0]  w_state_q, w_state_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [15:0] wcnt_q, wcnt_d;

    logic [1:0]  r_state_q, r_state_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
    logic [15:0] rcnt_q, rcnt_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] wr_addr, wr_data, wr_off, rd_addr, rd_off, rd_word;
    logic [3:0]  wr_strb;
    logic        wr_in_range, rd_in_range;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    assign aw_hs = AWvalid && awready_q;
    assign w_hs  = Wvalid && wready_q;
    assign ar_hs = ARvalid && arready_q;

    // Commit uses whichever half arrives this cycle, else the captured copy.
    assign wr_addr     = aw_hs ? AWdata : awaddr_q;
    assign wr_data     = w_hs ? Wdata : wdata_q;
    assign wr_strb     = w_hs ? Wstrb : wstrb_q;
    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = {1'b0, wr_off} < MEM_BYTES;
    assign wr_idx      = wr_off[ADDR_WIDTH+1:2];

    assign rd_addr     = (r_state_q == R_WAIT) ? araddr_q : ARdata;
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_off} < MEM_BYTES;
    assign rd_idx      = rd_off[ADDR_WIDTH+1:2];
    assign rd_word     = rd_in_range ? mem[rd_idx] : 32'h0;

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wcnt_d    = wcnt_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awaddr_d  = AWdata;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = Wdata;
                    wstrb_d  = Wstrb;
                    wready_d = 1'b0;
                end
                if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                    commit = 1'b1;
                    if (WAIT_ON) begin
                        w_state_d = W_WAIT;
                        wcnt_d    = '0;
                    end else begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            W_RESP: begin
                if (Bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    arready_d = 1'b0;
                    araddr_d  = ARdata;
                    if (WAIT_ON) begin
                        r_state_d = R_WAIT;
                        rcnt_d    = '0;
                    end else begin
                        r_state_d = R_DATA;
                        rdata_d   = rd_word;
                        rvalid_d  = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q == WAIT_LAST) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_word;
                    rvalid_d  = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 16'd1;
                end
            end
            R_DATA: begin
                if (RReady) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            wcnt_q    <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            wcnt_q    <= wcnt_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Captured payload needs no reset: it is only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
        araddr_q <= araddr_d;
    end

    // Same-edge read sees the old word because the array updates non-blocking.
    always_ff @(posedge clk) begin
        if (commit && wr_in_range && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign Bvalid  = bvalid_q;
    assign ARready = arready_q;
    assign Rvalid  = rvalid_q;
    assign Rdata   = rdata_q;

endmodule
